// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
package adc_pkg;
    localparam int ADC_W = 12;
    localparam int CH_W  = 3;
    localparam int N_CH  = 1 << CH_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
    typedef enum logic {ORG_SCAN, ORG_OS} origin_t;

    localparam logic [ADC_W-1:0] ERR_DATA = 12'hFFF;
endpackage

// File: rtl/adc_scan_ptr.sv
// Next set bit of the scan mask strictly after the pointer, wrapping; a lone
// set bit at the pointer itself is found last, so it gets reselected.
module adc_scan_ptr
    import adc_pkg::*;
(
    input  logic [N_CH-1:0] i_mask,
    input  logic [CH_W-1:0] i_ptr,
    output logic [CH_W-1:0] o_ch,
    output logic            o_found
);
    logic [CH_W-1:0] w_idx;

    // Walk offsets from far to near so the nearest hit is the last write.
    always_comb begin
        o_ch    = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            w_idx = i_ptr + CH_W'(i);
            if (i_mask[w_idx]) begin
                o_found = 1'b1;
                o_ch    = w_idx;
            end
        end
    end
endmodule

// File: rtl/adc_conv_scheduler.sv
// Shares one ADC frame engine between a background channel scanner and a
// one-shot requester, one conversion at a time, with timeout and idle gap.
module adc_conv_scheduler
    import adc_pkg::*;
#(
    parameter int GAP_W      = 16,
    parameter int MAX_OS_RUN = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk_50,
    input  logic              rst,
    output logic              conv_start,
    output logic [CH_W-1:0]   conv_ch,
    input  logic              conv_busy,
    input  logic              conv_done,
    input  logic [ADC_W-1:0]  conv_data,
    input  logic              scan_en,
    input  logic [N_CH-1:0]   scan_mask,
    input  logic [GAP_W-1:0]  scan_gap,
    input  logic              req_valid,
    input  logic [CH_W-1:0]   req_ch,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [CH_W-1:0]   rsp_ch,
    output logic [ADC_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [ADC_W-1:0]  res_data,
    output logic              res_err
);
    localparam int RUN_W = $clog2(MAX_OS_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_OS_RUN);
    // Compare one short of the last count so the registered error pulse
    // lands exactly TIMEOUT cycles after conv_start.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + RUN_W'(1);
    endfunction

    state_t           r_state, w_next;
    origin_t          r_org;
    logic [CH_W-1:0]  r_ch, r_ptr;
    logic [RUN_W-1:0] r_run;
    logic [TMO_W-1:0] r_tmo;
    logic [GAP_W-1:0] r_gap;
    logic             r_res_valid, r_res_err, r_rsp_valid, r_rsp_err;
    logic [CH_W-1:0]  r_res_ch, r_rsp_ch;
    logic [ADC_W-1:0] r_res_data, r_rsp_data;

    logic [CH_W-1:0]  w_scan_ch;
    logic             w_scan_found, w_scan_elig;
    logic             w_grant_os, w_grant_scan, w_start;
    logic             w_done_hit, w_tmo_hit, w_finish;
    logic [ADC_W-1:0] w_result;

    adc_scan_ptr u_scan_ptr (
        .i_mask  (scan_mask),
        .i_ptr   (r_ptr),
        .o_ch    (w_scan_ch),
        .o_found (w_scan_found)
    );

    assign w_scan_elig = scan_en && w_scan_found;

    always_comb begin
        w_next       = r_state;
        w_grant_os   = 1'b0;
        w_grant_scan = 1'b0;
        w_start      = 1'b0;
        w_done_hit   = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_scan_elig && (!req_valid || r_run == RUN_MAX)) begin
                    w_grant_scan = 1'b1;
                    w_next       = ISSUE;
                end else if (req_valid) begin
                    w_grant_os = 1'b1;
                    w_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (!conv_busy) begin
                    w_start = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (conv_done) begin
                    w_done_hit = 1'b1;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                end
                if (conv_done || r_tmo == TMO_LAST) begin
                    w_next = (scan_gap == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_finish = w_done_hit || w_tmo_hit;
    assign w_result = w_done_hit ? conv_data : ERR_DATA;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_org       <= ORG_SCAN;
            r_ch        <= '0;
            r_ptr       <= CH_W'(N_CH - 1);
            r_run       <= '0;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ch    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (w_grant_os) begin
                r_ch  <= req_ch;
                r_org <= ORG_OS;
                r_run <= sat_inc(r_run);
            end
            if (w_grant_scan) begin
                r_ch  <= w_scan_ch;
                r_org <= ORG_SCAN;
                r_run <= '0;
            end
            if (w_start) begin
                r_tmo <= '0;
            end else if (r_state == WAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            // Entering GAP with scan_gap-1 gives exactly scan_gap GAP cycles.
            if (w_finish) begin
                r_gap <= scan_gap - GAP_W'(1);
                if (r_org == ORG_SCAN) begin
                    r_res_valid <= 1'b1;
                    r_res_ch    <= r_ch;
                    r_res_data  <= w_result;
                    r_res_err   <= w_tmo_hit;
                    r_ptr       <= r_ch;
                end else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_ch    <= r_ch;
                    r_rsp_data  <= w_result;
                    r_rsp_err   <= w_tmo_hit;
                end
            end else if (r_state == GAP && r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign conv_start = w_start && !rst;
    assign req_ready  = w_grant_os && !rst;
    assign conv_ch    = r_ch;
    assign res_valid  = r_res_valid;
    assign res_ch     = r_res_ch;
    assign res_data   = r_res_data;
    assign res_err    = r_res_err;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_ch     = r_rsp_ch;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler with a behavioural frame engine.
module tb_adc_conv_scheduler;
    localparam int GAP_W = 16;

    logic             clk_50 = 1'b0;
    logic             rst;
    logic             conv_start;
    logic [2:0]       conv_ch;
    logic             conv_busy;
    logic             conv_done;
    logic [11:0]      conv_data;
    logic             scan_en;
    logic [7:0]       scan_mask;
    logic [GAP_W-1:0] scan_gap;
    logic             req_valid;
    logic [2:0]       req_ch;
    logic             req_ready;
    logic             rsp_valid;
    logic [2:0]       rsp_ch;
    logic [11:0]      rsp_data;
    logic             rsp_err;
    logic             res_valid;
    logic [2:0]       res_ch;
    logic [11:0]      res_data;
    logic             res_err;

    always #5 clk_50 = ~clk_50;

    adc_conv_scheduler #(.GAP_W(GAP_W), .MAX_OS_RUN(2), .TIMEOUT(1024)) dut (
        .clk_50(clk_50), .rst(rst),
        .conv_start(conv_start), .conv_ch(conv_ch), .conv_busy(conv_busy),
        .conv_done(conv_done), .conv_data(conv_data),
        .scan_en(scan_en), .scan_mask(scan_mask), .scan_gap(scan_gap),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .res_err(res_err)
    );

    typedef struct {
        bit         os;
        logic [2:0] ch;
        bit         err;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] dq[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int gap_meas = -1, tmo_lat = -1;
    int n_ready = 0, n_res = 0;
    int eng_lat = 40;
    bit eng_hang = 1'b0;
    int eng_seq = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit os, input logic [2:0] ch, input bit err);
        exp_t e;
        e.os  = os;
        e.ch  = ch;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic check_result(input bit os, input logic [2:0] ch,
                                input logic [11:0] data, input bit err);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("origin", 64'(os), 64'(e.os));
            chk("ch", 64'(ch), 64'(e.ch));
            chk("err", 64'(err), 64'(e.err));
            if (e.err) begin
                chk("err_data", 64'(data), 64'hFFF);
                tmo_lat = cyc - start_cyc;
            end else if (dq.size() == 0) begin
                chk("data_queue", 64'(dq.size()), 64'd1);
            end else begin
                chk("data", 64'(data), 64'(dq.pop_front()));
            end
        end
    endtask

    // Frame engine: busy from the cycle after conv_start, done eng_lat cycles
    // after conv_start; in hang mode it stays busy a long time and never ends.
    initial begin
        bit hang;
        conv_busy = 1'b0;
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge clk_50);
            if (conv_start === 1'b1) begin
                hang = eng_hang;
                @(posedge clk_50); #1;
                conv_busy = 1'b1;
                if (hang) begin
                    repeat (1100) @(posedge clk_50);
                    #1 conv_busy = 1'b0;
                end else begin
                    repeat (eng_lat - 1) @(posedge clk_50);
                    #1;
                    eng_seq++;
                    conv_data = 12'(eng_seq * 371 + 5);
                    conv_done = 1'b1;
                    dq.push_back(conv_data);
                    @(posedge clk_50); #1;
                    conv_done = 1'b0;
                    conv_busy = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk_50);
            cyc++;
            if (conv_done === 1'b1) done_cyc = cyc;
            if (conv_start === 1'b1) begin
                chk("start_while_busy", 64'(conv_busy), 64'd0);
                gap_meas  = cyc - done_cyc - 2;
                start_cyc = cyc;
            end
            if (req_ready === 1'b1) n_ready++;
            if (res_valid === 1'b1 || rsp_valid === 1'b1) n_res++;
            if (res_valid === 1'b1) check_result(1'b0, res_ch, res_data, res_err);
            if (rsp_valid === 1'b1) check_result(1'b1, rsp_ch, rsp_data, rsp_err);
        end
    end

    task automatic run_starts(input int n, input int budget);
        int seen = 0;
        int left = budget;
        while (seen < n && left > 0) begin
            @(negedge clk_50);
            if (conv_start === 1'b1) seen++;
            left--;
        end
        if (seen < n) chk("start_count", 64'(seen), 64'(n));
    endtask

    task automatic wait_drain(input int budget);
        int left = budget;
        while (exp_q.size() != 0 && left > 0) begin
            @(negedge clk_50);
            left--;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        int left = 5000;
        while (conv_busy === 1'b1 && left > 0) begin
            @(negedge clk_50);
            left--;
        end
        @(posedge clk_50); #1 rst = 1'b1;
        repeat (2) @(posedge clk_50);
        #1 rst = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({conv_start, conv_ch, req_ready, rsp_valid, rsp_ch, rsp_data, rsp_err,
                    res_valid, res_ch, res_data, res_err});
    endfunction

    initial begin
        int n0;
        rst       = 1'b1;
        scan_en   = 1'b0;
        scan_mask = '0;
        scan_gap  = '0;
        req_valid = 1'b0;
        req_ch    = '0;
        repeat (3) @(posedge clk_50);
        #1 rst = 1'b0;
        @(negedge clk_50);
        chk("reset_outputs", all_outs(), 64'd0);

        // Scan only: channels 5,6,7,5,6
        scan_mask = 8'hE0;
        eng_lat   = 40;
        foreach (exp_q[i]) exp_q.delete(i);
        push_exp(0, 3'd5, 0); push_exp(0, 3'd6, 0); push_exp(0, 3'd7, 0);
        push_exp(0, 3'd5, 0); push_exp(0, 3'd6, 0);
        scan_en = 1'b1;
        run_starts(5, 2000);
        scan_en = 1'b0;
        wait_drain(500);

        // One-shot priority with fairness
        @(posedge clk_50); #1;
        eng_lat   = 8;
        n_ready   = 0;
        scan_mask = 8'h20;
        req_ch    = 3'd2;
        push_exp(1, 3'd2, 0); push_exp(1, 3'd2, 0); push_exp(0, 3'd5, 0);
        push_exp(1, 3'd2, 0); push_exp(1, 3'd2, 0); push_exp(0, 3'd5, 0);
        req_valid = 1'b1;
        scan_en   = 1'b1;
        run_starts(6, 500);
        req_valid = 1'b0;
        scan_en   = 1'b0;
        wait_drain(200);
        chk("req_ready_count", 64'(n_ready), 64'd4);

        // Timeout on ch5, then ch6 proceeds
        do_reset();
        scan_mask = 8'hE0;
        eng_lat   = 20;
        eng_hang  = 1'b1;
        tmo_lat   = -1;
        push_exp(0, 3'd5, 1); push_exp(0, 3'd6, 0);
        scan_en = 1'b1;
        run_starts(1, 100);
        @(posedge clk_50); #1 eng_hang = 1'b0;
        run_starts(1, 3000);
        scan_en = 1'b0;
        wait_drain(200);
        chk("timeout_latency", 64'(tmo_lat), 64'd1024);

        // Idle gap of 100 cycles
        do_reset();
        scan_mask = 8'h20;
        scan_gap  = 16'd100;
        eng_lat   = 10;
        push_exp(0, 3'd5, 0); push_exp(0, 3'd5, 0);
        scan_en = 1'b1;
        run_starts(2, 500);
        scan_en = 1'b0;
        wait_drain(200);
        chk("gap_cycles", 64'(gap_meas), 64'd100);
        scan_gap = '0;

        // Reset in WAIT, stray done three cycles later
        do_reset();
        scan_mask = 8'hE0;
        eng_lat   = 13;
        scan_en   = 1'b1;
        run_starts(1, 100);
        n0 = n_res;
        repeat (10) @(posedge clk_50);
        #1 rst = 1'b1;
        @(posedge clk_50);
        #1 rst = 1'b0;
        @(negedge clk_50);
        chk("midwait_reset_outputs", all_outs(), 64'd0);
        run_starts(1, 100);
        chk("post_reset_ch", 64'(conv_ch), 64'd5);
        chk("no_pulse_after_reset", 64'(n_res - n0), 64'd0);
        dq.delete();
        push_exp(0, 3'd5, 0);
        scan_en = 1'b0;
        wait_drain(200);

        // Wrap with mask 81, then single-bit mask 08
        do_reset();
        scan_mask = 8'h81;
        eng_lat   = 8;
        push_exp(0, 3'd0, 0); push_exp(0, 3'd7, 0);
        push_exp(0, 3'd0, 0); push_exp(0, 3'd7, 0);
        scan_en = 1'b1;
        run_starts(4, 500);
        scan_mask = 8'h08;
        push_exp(0, 3'd3, 0); push_exp(0, 3'd3, 0); push_exp(0, 3'd3, 0);
        run_starts(3, 500);
        scan_en = 1'b0;
        wait_drain(200);

        repeat (5) @(posedge clk_50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
